// File: rtl/avr_prog_loader.sv
// avr_prog_loader
// Boot-time loader sitting in front of program memory. Accepts a framed byte
// stream (SYNC, LEN_L, LEN_H, {W_L, W_H} x LEN, CSUM), packs little-endian
// byte pairs into 16-bit instruction words, writes them as they arrive and
// keeps the CPU held until a complete frame with a good checksum is loaded.
module avr_prog_loader #(
  parameter int         ADDR_W  = 9,
  parameter logic [7:0] SYNC    = 8'h55,
  parameter int         TIMEOUT = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              pm_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_LEN_L     = 3'd1,
    ST_LEN_H     = 3'd2,
    ST_DATA_L    = 3'd3,
    ST_DATA_H    = 3'd4,
    ST_CSUM      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int IDX_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  // Largest frame that fits in program memory: 2**ADDR_W words
  localparam logic [16:0]       MAX_LEN   = 17'd1 << ADDR_W;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  // Frame checksum is a plain modulo-256 byte sum
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t            state_r;
  logic [15:0]       len_r;
  logic [7:0]        sum_r;
  logic [7:0]        low_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDLE_W-1:0] idle_r;

  logic [15:0]       len_full_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [7:0]        sum_next_s;
  logic              last_word_s;

  // Length as it will be once the LEN_H byte lands; decided on the same edge
  assign len_full_s  = {rx_data, len_r[7:0]};
  assign idx_next_s  = idx_r + IDX_W'(1);
  assign sum_next_s  = csum_add(sum_r, rx_data);
  assign last_word_s = (17'(idx_next_s) == {1'b0, len_r});

  // Frame parser, word packer, timeout watchdog and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_WAIT_SYNC;
      len_r    <= 16'd0;
      sum_r    <= 8'd0;
      low_r    <= 8'd0;
      idx_r    <= '0;
      idle_r   <= '0;
      pm_addr  <= '0;
      pm_wdata <= 16'd0;
      pm_we    <= 1'b0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= ERR_NONE;
    end else begin
      // Write strobe is a single-cycle pulse per completed word
      pm_we <= 1'b0;
      case (state_r)
        ST_WAIT_SYNC: begin
          if (rx_valid && (rx_data == SYNC)) begin
            state_r <= ST_LEN_L;
            err     <= ERR_NONE;
            idx_r   <= '0;
            sum_r   <= 8'd0;
            idle_r  <= '0;
            busy    <= 1'b1;
          end
        end

        ST_DONE: begin
          // Incoming bytes are ignored here; only reload restarts loading
          if (reload) begin
            state_r  <= ST_WAIT_SYNC;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        ST_LEN_L, ST_LEN_H, ST_DATA_L, ST_DATA_H, ST_CSUM: begin
          if (rx_valid) begin
            idle_r <= '0;
            sum_r  <= sum_next_s;
            case (state_r)
              ST_LEN_L: begin
                len_r[7:0] <= rx_data;
                state_r    <= ST_LEN_H;
              end
              ST_LEN_H: begin
                len_r[15:8] <= rx_data;
                if ({1'b0, len_full_s} > MAX_LEN) begin
                  err     <= ERR_LEN;
                  state_r <= ST_WAIT_SYNC;
                  busy    <= 1'b0;
                end else if (len_full_s == 16'd0) begin
                  state_r <= ST_CSUM;
                end else begin
                  state_r <= ST_DATA_L;
                end
              end
              ST_DATA_L: begin
                low_r   <= rx_data;
                state_r <= ST_DATA_H;
              end
              ST_DATA_H: begin
                pm_we    <= 1'b1;
                pm_addr  <= idx_r[ADDR_W-1:0];
                pm_wdata <= {rx_data, low_r};
                idx_r    <= idx_next_s;
                state_r  <= last_word_s ? ST_CSUM : ST_DATA_L;
              end
              ST_CSUM: begin
                busy <= 1'b0;
                if (sum_next_s == 8'd0) begin
                  state_r  <= ST_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  state_r <= ST_WAIT_SYNC;
                  err     <= ERR_CSUM;
                end
              end
              default: begin
                state_r <= ST_WAIT_SYNC;
                busy    <= 1'b0;
              end
            endcase
          end else if (idle_r == IDLE_LAST) begin
            // Sender went quiet mid-frame: abandon it, written words stay
            err     <= ERR_TOUT;
            state_r <= ST_WAIT_SYNC;
            busy    <= 1'b0;
          end else begin
            idle_r <= idle_r + IDLE_W'(1);
          end
        end

        default: begin
          state_r  <= ST_WAIT_SYNC;
          busy     <= 1'b0;
          done     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule
